// File: rtl/counter_seq_ctrl.sv
// Purpose: sequences an external free-running counter from a preload value to a terminal count, once or repeatedly.
// Latency: LOAD strobe the cycle after start is accepted; done pulses the cycle after the matching RUN cycle.
// Backpressure: none; start while busy is dropped, abort returns to IDLE at the next edge.
module counter_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  cfg_start,
    input  logic [WIDTH-1:0]  cfg_end,
    input  logic              cfg_repeat,
    input  logic              abort,
    input  logic [WIDTH-1:0]  cnt_count,
    output logic              cnt_load,
    output logic [WIDTH-1:0]  cnt_load_data,
    output logic              busy,
    output logic              done,
    output logic [PASS_W-1:0] pass_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    start_val_q, start_val_d;
    logic [WIDTH-1:0]    end_val_q, end_val_d;
    logic                repeat_q, repeat_d;
    logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic                cnt_load_q, cnt_load_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d     = state_q;
        start_val_d = start_val_q;
        end_val_d   = end_val_q;
        repeat_d    = repeat_q;
        pass_cnt_d  = pass_cnt_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    start_val_d = cfg_start;
                    end_val_d   = cfg_end;
                    repeat_d    = cfg_repeat;
                    pass_cnt_d  = '0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                state_d = abort ? IDLE : RUN;
            end
            RUN: begin
                // abort wins over a coincident match: no increment, no done
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_count == end_val_q) begin
                    if (pass_cnt_q != {PASS_W{1'b1}}) begin
                        pass_cnt_d = pass_cnt_q + PASS_W'(1);
                    end
                    state_d = repeat_q ? LOAD : DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // outputs are registered copies decoded from the next state
        cnt_load_d = (state_d == LOAD);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            start_val_q <= '0;
            end_val_q   <= '0;
            repeat_q    <= 1'b0;
            pass_cnt_q  <= '0;
            cnt_load_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_val_q <= start_val_d;
            end_val_q   <= end_val_d;
            repeat_q    <= repeat_d;
            pass_cnt_q  <= pass_cnt_d;
            cnt_load_q  <= cnt_load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cnt_load      = cnt_load_q;
    assign cnt_load_data = start_val_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass_cnt      = pass_cnt_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural model of the controlled counter.
module tb_counter_seq_ctrl;

    localparam int WIDTH  = 4;
    localparam int PASS_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [WIDTH-1:0]  cfg_start;
    logic [WIDTH-1:0]  cfg_end;
    logic              cfg_repeat;
    logic              abort;
    logic [WIDTH-1:0]  cnt_count = '0;
    logic              cnt_load;
    logic [WIDTH-1:0]  cnt_load_data;
    logic              busy;
    logic              done;
    logic [PASS_W-1:0] pass_cnt;

    int vectors     = 0;
    int miscompares = 0;

    counter_seq_ctrl #(.WIDTH(WIDTH), .PASS_W(PASS_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cfg_start     (cfg_start),
        .cfg_end       (cfg_end),
        .cfg_repeat    (cfg_repeat),
        .abort         (abort),
        .cnt_count     (cnt_count),
        .cnt_load      (cnt_load),
        .cnt_load_data (cnt_load_data),
        .busy          (busy),
        .done          (done),
        .pass_cnt      (pass_cnt)
    );

    always #5 clk = ~clk;

    // controlled counter: load on strobe, otherwise increment modulo 2^WIDTH
    always_ff @(posedge clk) begin
        if (cnt_load) cnt_count <= cnt_load_data;
        else          cnt_count <= cnt_count + WIDTH'(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_single(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] e,
                              input int len, input string tag);
        logic [WIDTH-1:0] ex;
        cfg_start = s; cfg_end = e; cfg_repeat = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_load"},      32'(cnt_load),      32'd1);
        chk({tag, "_load_data"}, 32'(cnt_load_data), 32'(s));
        chk({tag, "_pass_clr"},  32'(pass_cnt),      32'd0);
        chk({tag, "_busy_load"}, 32'(busy),          32'd1);
        tick();
        for (int i = 0; i < len; i++) begin
            ex = s + WIDTH'(i);
            chk({tag, "_run_cnt"},  32'(cnt_count), 32'(ex));
            chk({tag, "_run_load"}, 32'(cnt_load),  32'd0);
            chk({tag, "_run_done"}, 32'(done),      32'd0);
            chk({tag, "_run_busy"}, 32'(busy),      32'd1);
            tick();
        end
        chk({tag, "_done"},      32'(done),     32'd1);
        chk({tag, "_pass"},      32'(pass_cnt), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy),     32'd1);
        tick();
        chk({tag, "_done_fall"}, 32'(done), 32'd0);
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] ex;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_start = '0; cfg_end = '0; cfg_repeat = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_load",      32'(cnt_load),      32'd0);
        chk("rst_load_data", 32'(cnt_load_data), 32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_done",      32'(done),          32'd0);
        chk("rst_pass",      32'(pass_cnt),      32'd0);

        // single pass, plain, wrapping and equal start/end
        run_single(4'd2,  4'd5, 4, "single");
        run_single(4'd14, 4'd1, 4, "wrap");
        run_single(4'd7,  4'd7, 1, "equal");

        // abort together with start in IDLE: start dropped
        start = 1'b1; abort = 1'b1; cfg_start = 4'd3; cfg_end = 4'd6;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_start_busy", 32'(busy),     32'd0);
        chk("idle_abort_start_load", 32'(cnt_load), 32'd0);
        chk("idle_abort_start_pass", 32'(pass_cnt), 32'd1);

        // repeat mode: LOAD, RUN 0,1,2 every 4 cycles
        cfg_start = 4'd0; cfg_end = 4'd2; cfg_repeat = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("rep_first_load", 32'(cnt_load), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                ex = WIDTH'(i);
                chk("rep_run_cnt",  32'(cnt_count), 32'(ex));
                chk("rep_run_load", 32'(cnt_load),  32'd0);
                chk("rep_run_pass", 32'(pass_cnt),  32'(k - 1));
                tick();
            end
            chk("rep_reload", 32'(cnt_load), 32'd1);
            chk("rep_pass",   32'(pass_cnt), 32'(k));
            chk("rep_done",   32'(done),     32'd0);
            chk("rep_busy",   32'(busy),     32'd1);
        end
        tick();
        chk("rep_run_again", 32'(cnt_count), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("rep_abort_busy", 32'(busy),     32'd0);
        chk("rep_abort_load", 32'(cnt_load), 32'd0);
        chk("rep_abort_done", 32'(done),     32'd0);
        chk("rep_abort_pass", 32'(pass_cnt), 32'd4);
        tick();
        chk("rep_abort_stay", 32'(busy), 32'd0);

        // start mid-RUN with other config is ignored; abort on the match cycle
        cfg_start = 4'd1; cfg_end = 4'd4; cfg_repeat = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid_cnt1", 32'(cnt_count), 32'd1);
        start = 1'b1; cfg_start = 4'd9; cfg_end = 4'd2; cfg_repeat = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_cnt2",      32'(cnt_count),     32'd2);
        chk("mid_busy",      32'(busy),          32'd1);
        chk("mid_load",      32'(cnt_load),      32'd0);
        chk("mid_load_data", 32'(cnt_load_data), 32'd1);
        chk("mid_pass",      32'(pass_cnt),      32'd0);
        tick();
        chk("mid_cnt3", 32'(cnt_count), 32'd3);
        tick();
        chk("mid_cnt4", 32'(cnt_count), 32'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_match_busy", 32'(busy),     32'd0);
        chk("abort_match_done", 32'(done),     32'd0);
        chk("abort_match_pass", 32'(pass_cnt), 32'd0);
        chk("abort_match_load", 32'(cnt_load), 32'd0);
        tick();
        chk("abort_match_done2", 32'(done), 32'd0);

        // reset mid-RUN, then a clean sequence
        cfg_start = 4'd5; cfg_end = 4'd10; cfg_repeat = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy",      32'(busy),          32'd0);
        chk("midrst_done",      32'(done),          32'd0);
        chk("midrst_load",      32'(cnt_load),      32'd0);
        chk("midrst_load_data", 32'(cnt_load_data), 32'd0);
        chk("midrst_pass",      32'(pass_cnt),      32'd0);
        tick();
        chk("midrst_done2", 32'(done), 32'd0);
        run_single(4'd3, 4'd4, 2, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
